// File: rtl/ads78xx_pkg.sv
// Shared types and elaboration-time helpers for the ADS78xx multi-channel controller.
package ads78xx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_e;

  localparam int MAX_FRAME_BITS = 64;

  function automatic int frame_bits(input int data_w, input int lead, input int trail);
    return lead + data_w + trail;
  endfunction

  // Bit k set when frame bit k carries conversion data.
  function automatic logic [MAX_FRAME_BITS-1:0] data_mask(input int lead, input int data_w);
    logic [MAX_FRAME_BITS-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_FRAME_BITS; k++) begin
      if (k >= lead && k < lead + data_w) m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic bit params_ok(input int data_w, input int lead, input int trail,
                                   input int n_ch, input int clk_div, input int cs_setup,
                                   input int quiet_cyc, input int sample_period);
    int fb;
    int len;
    fb  = frame_bits(data_w, lead, trail);
    len = cs_setup + 2 * clk_div * fb;
    return (data_w >= 8) && (data_w <= 16) && (n_ch >= 1) && (n_ch <= 8) &&
           (clk_div >= 1) && (cs_setup >= 1) && (quiet_cyc >= 1) &&
           (sample_period > len) && (fb <= MAX_FRAME_BITS);
  endfunction

endpackage

// File: rtl/ads78xx_sclk_gen.sv
// SCLK divider for the SHIFT phase: low half then high half per bit, with a
// mid-bit sample strobe, an end-of-frame strobe and the current bit index.
module ads78xx_sclk_gen
  import ads78xx_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 16,
  parameter int BIT_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic             sclk_o,
  output logic             rise_o,
  output logic             last_o,
  output logic [BIT_W-1:0] bit_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             half_end;

  assign half_end = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    if (!en_i) begin
      div_d   = '0;
      phase_d = 1'b0;
      bit_d   = '0;
    end else if (half_end) begin
      div_d   = '0;
      phase_d = ~phase_q;
      if (phase_q) bit_d = bit_q + BIT_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
    end
  end

  // phase 0 is the low half; outside SHIFT the line idles high
  assign sclk_o = ~(en_i & ~phase_q);
  assign rise_o = en_i & ~phase_q & half_end;
  assign last_o = en_i & phase_q & half_end & (bit_q == BIT_W'(FRAME_BITS - 1));
  assign bit_o  = bit_q;

endmodule

// File: rtl/ads78xx_multi_ctrl.sv
// Controller for N_CH ADS78xx ADCs sharing SCLK/nCS; captures all SDO lines in
// parallel and presents one aligned sample vector per frame.
module ads78xx_multi_ctrl
  import ads78xx_pkg::*;
#(
  parameter int DATA_W        = 12,
  parameter int LEAD_ZEROS    = 2,
  parameter int TRAIL_ZEROS   = 2,
  parameter int N_CH          = 4,
  parameter int CLK_DIV       = 2,
  parameter int CS_SETUP      = 2,
  parameter int QUIET_CYC     = 4,
  parameter int SAMPLE_PERIOD = 200,
  parameter int TWOS_COMP     = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   cont_en_i,
  input  logic [N_CH-1:0]        adc_sdo_i,
  output logic                   adc_sclk_o,
  output logic                   adc_ncs_o,
  output logic [N_CH*DATA_W-1:0] adc_data_o,
  output logic                   data_valid_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int FB      = frame_bits(DATA_W, LEAD_ZEROS, TRAIL_ZEROS);
  localparam int BIT_W   = $clog2(FB);
  localparam int CNT_MAX = (CS_SETUP > QUIET_CYC) ? CS_SETUP : QUIET_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TMR_W   = $clog2(SAMPLE_PERIOD);
  localparam logic [MAX_FRAME_BITS-1:0] DATA_MASK = data_mask(LEAD_ZEROS, DATA_W);
  localparam logic [DATA_W-1:0] MSB_FLIP =
    (TWOS_COMP != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

  if (!params_ok(DATA_W, LEAD_ZEROS, TRAIL_ZEROS, N_CH, CLK_DIV, CS_SETUP,
                 QUIET_CYC, SAMPLE_PERIOD)) begin : g_param_err
    $error("ads78xx_multi_ctrl: illegal parameter combination");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   timer_q;
  logic               tick, trig, load;
  logic               sclk, rise, last;
  logic [BIT_W-1:0]   bit_idx;
  logic [DATA_W-1:0]  sr_q [N_CH];
  logic [N_CH*DATA_W-1:0] adc_data_q;
  logic               data_valid_q, overrun_q;

  // Timer is held at 0 while disabled, so the enabling cycle ticks at once.
  assign tick = cont_en_i & (timer_q == '0);
  assign trig = cont_en_i ? tick : start_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || !cont_en_i)                     timer_q <= '0;
    else if (timer_q == TMR_W'(SAMPLE_PERIOD-1)) timer_q <= '0;
    else                                         timer_q <= timer_q + TMR_W'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (trig) state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP-1)) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        cnt_d = '0;
        if (last) begin
          load    = 1'b1;
          state_d = QUIET;
        end
      end
      QUIET: begin
        if (cnt_q == CNT_W'(QUIET_CYC-1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  ads78xx_sclk_gen #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FB),
    .BIT_W      (BIT_W)
  ) u_sclk_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q == SHIFT),
    .sclk_o (sclk),
    .rise_o (rise),
    .last_o (last),
    .bit_o  (bit_idx)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    always_ff @(posedge clk_i) begin
      if (rst_i)                           sr_q[g] <= '0;
      else if (rise && DATA_MASK[bit_idx]) sr_q[g] <= {sr_q[g][DATA_W-2:0], adc_sdo_i[g]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adc_data_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= load;
      if (load) begin
        for (int i = 0; i < N_CH; i++) adc_data_q[i*DATA_W +: DATA_W] <= sr_q[i] ^ MSB_FLIP;
      end
    end
  end

  // Sticky until the continuous mode is switched off.
  always_ff @(posedge clk_i) begin
    if (rst_i || !cont_en_i)          overrun_q <= 1'b0;
    else if (tick && state_q != IDLE) overrun_q <= 1'b1;
  end

  assign adc_sclk_o   = sclk;
  assign adc_ncs_o    = ~((state_q == SETUP) || (state_q == SHIFT));
  assign adc_data_o   = adc_data_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = (state_q != IDLE);
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_ads78xx_multi_ctrl.sv
// Bench for ads78xx_multi_ctrl: two instances (defaults, and an 8-bit two's-complement
// variant with a short sample period) driven by behavioural ADC models.
module tb_ads78xx_multi_ctrl;

  localparam int A_N = 4, A_DW = 12, A_LEAD = 2, A_LAT = 67, A_NCS = 66, A_BUSY = 70;
  localparam int B_N = 2, B_DW = 8,  B_LEAD = 4, B_LAT = 35, B_NCS = 34, B_BUSY = 44;
  localparam int FB  = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic                a_rst = 1'b1, a_start = 1'b0, a_cont = 1'b0;
  logic [A_N-1:0]      a_sdo = '0;
  logic                a_sclk, a_ncs, a_dv, a_busy, a_ovr;
  logic [A_N*A_DW-1:0] a_data;
  logic                b_rst = 1'b1, b_start = 1'b0, b_cont = 1'b0;
  logic [B_N-1:0]      b_sdo = '0;
  logic                b_sclk, b_ncs, b_dv, b_busy, b_ovr;
  logic [B_N*B_DW-1:0] b_data;

  ads78xx_multi_ctrl u_a (
    .clk_i(clk), .rst_i(a_rst), .start_i(a_start), .cont_en_i(a_cont), .adc_sdo_i(a_sdo),
    .adc_sclk_o(a_sclk), .adc_ncs_o(a_ncs), .adc_data_o(a_data), .data_valid_o(a_dv),
    .busy_o(a_busy), .overrun_o(a_ovr)
  );

  ads78xx_multi_ctrl #(
    .DATA_W(8), .LEAD_ZEROS(4), .TRAIL_ZEROS(4), .N_CH(2), .CLK_DIV(1), .CS_SETUP(2),
    .QUIET_CYC(10), .SAMPLE_PERIOD(40), .TWOS_COMP(1)
  ) u_b (
    .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .cont_en_i(b_cont), .adc_sdo_i(b_sdo),
    .adc_sclk_o(b_sclk), .adc_ncs_o(b_ncs), .adc_data_o(b_data), .data_valid_o(b_dv),
    .busy_o(b_busy), .overrun_o(b_ovr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC models: a new code is latched at nCS fall and its expected output is queued.
  // Non-data frame bits carry random junk the controller must ignore.
  logic [A_DW-1:0]     a_val [A_N];
  logic [A_DW-1:0]     a_fix [A_N];
  logic                a_fixed = 1'b0;
  int                  a_k = 0;
  logic [A_N*A_DW-1:0] a_exp_q[$];
  logic [B_DW-1:0]     b_val [B_N];
  logic [B_DW-1:0]     b_fix [B_N];
  logic                b_fixed = 1'b0;
  int                  b_k = 0;
  logic [B_N*B_DW-1:0] b_exp_q[$];

  always @(negedge a_ncs) begin
    logic [A_N*A_DW-1:0] e;
    for (int c = 0; c < A_N; c++) begin
      a_val[c] = a_fixed ? a_fix[c] : A_DW'($urandom_range(0, (1 << A_DW) - 1));
      e[c*A_DW +: A_DW] = a_val[c];
    end
    a_exp_q.push_back(e);
    a_k   = 0;
    a_sdo = A_N'($urandom);
  end

  always @(negedge a_sclk) if (a_ncs === 1'b0) begin
    for (int c = 0; c < A_N; c++)
      a_sdo[c] = (a_k >= A_LEAD && a_k < A_LEAD + A_DW) ? a_val[c][A_DW-1-(a_k-A_LEAD)]
                                                        : 1'($urandom);
    a_k++;
  end

  always @(negedge b_ncs) begin
    logic [B_N*B_DW-1:0] e;
    int ev;
    for (int c = 0; c < B_N; c++) begin
      b_val[c] = b_fixed ? b_fix[c] : B_DW'($urandom_range(0, (1 << B_DW) - 1));
      // offset binary to two's complement: subtract half scale, modulo 2^DW
      ev = (int'(b_val[c]) + (1 << (B_DW - 1))) % (1 << B_DW);
      e[c*B_DW +: B_DW] = B_DW'(ev);
    end
    b_exp_q.push_back(e);
    b_k   = 0;
    b_sdo = B_N'($urandom);
  end

  always @(negedge b_sclk) if (b_ncs === 1'b0) begin
    for (int c = 0; c < B_N; c++)
      b_sdo[c] = (b_k >= B_LEAD && b_k < B_LEAD + B_DW) ? b_val[c][B_DW-1-(b_k-B_LEAD)]
                                                        : 1'($urandom);
    b_k++;
  end

  // scoreboard monitors
  int   a_dv_cnt = 0, a_ncs_len = 0, a_pulses = 0, a_busy_len = 0;
  int   a_dv_log[$];
  logic a_ncs_p = 1'b1, a_sclk_p = 1'b1, a_busy_p = 1'b0, a_skip = 1'b0;
  int   b_dv_cnt = 0, b_ncs_len = 0, b_pulses = 0, b_busy_len = 0;
  int   b_dv_log[$];
  logic b_ncs_p = 1'b1, b_sclk_p = 1'b1, b_busy_p = 1'b0;

  always @(negedge clk) begin
    if (a_dv === 1'b1) begin
      a_dv_cnt++;
      a_dv_log.push_back(cyc);
      if (a_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_dv_unexpected: data_valid with data %0h, expected none", a_data);
      end else chk("a_data", a_data, a_exp_q.pop_front());
    end
    if (a_ncs === 1'b0) begin
      a_ncs_len++;
      if (a_sclk === 1'b1 && a_sclk_p === 1'b0) a_pulses++;
    end
    if (a_ncs === 1'b1 && a_ncs_p === 1'b0) begin
      if (!a_skip) begin
        chk("a_ncs_low_len", a_ncs_len, A_NCS);
        chk("a_sclk_pulses", a_pulses, FB);
      end
      a_ncs_len = 0; a_pulses = 0;
    end
    if (a_busy === 1'b1) a_busy_len++;
    else if (a_busy_p === 1'b1) begin
      if (!a_skip) chk("a_busy_len", a_busy_len, A_BUSY);
      a_busy_len = 0;
    end
    a_ncs_p = a_ncs; a_sclk_p = a_sclk; a_busy_p = a_busy;
  end

  always @(negedge clk) begin
    if (b_dv === 1'b1) begin
      b_dv_cnt++;
      b_dv_log.push_back(cyc);
      if (b_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_dv_unexpected: data_valid with data %0h, expected none", b_data);
      end else chk("b_data", b_data, b_exp_q.pop_front());
    end
    if (b_ncs === 1'b0) begin
      b_ncs_len++;
      if (b_sclk === 1'b1 && b_sclk_p === 1'b0) b_pulses++;
    end
    if (b_ncs === 1'b1 && b_ncs_p === 1'b0) begin
      chk("b_ncs_low_len", b_ncs_len, B_NCS);
      chk("b_sclk_pulses", b_pulses, FB);
      b_ncs_len = 0; b_pulses = 0;
    end
    if (b_busy === 1'b1) b_busy_len++;
    else if (b_busy_p === 1'b1) begin
      chk("b_busy_len", b_busy_len, B_BUSY);
      b_busy_len = 0;
    end
    b_ncs_p = b_ncs; b_sclk_p = b_sclk; b_busy_p = b_busy;
  end

  // driver tasks
  task automatic a_shot(input bit extra_start);
    int s, n0, t;
    n0 = a_dv_cnt;
    s  = cyc;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    if (extra_start) begin
      repeat (10) @(negedge clk);
      a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    end
    t = 0;
    while (a_dv_cnt == n0 && t < 300) begin @(negedge clk); t++; end
    if (a_dv_cnt == n0) begin
      checks++; errors++;
      $display("FAIL a_dv_timeout: no data_valid within 300 cycles, expected one");
    end else chk("a_latency", a_dv_log[$] - s, A_LAT);
    repeat (120) @(negedge clk);
    chk("a_one_frame_per_start", a_dv_cnt - n0, 1);
  endtask

  task automatic b_shot();
    int s, n0, t;
    n0 = b_dv_cnt;
    s  = cyc;
    b_start = 1'b1; @(negedge clk); b_start = 1'b0;
    t = 0;
    while (b_dv_cnt == n0 && t < 200) begin @(negedge clk); t++; end
    if (b_dv_cnt == n0) begin
      checks++; errors++;
      $display("FAIL b_dv_timeout: no data_valid within 200 cycles, expected one");
    end else chk("b_latency", b_dv_log[$] - s, B_LAT);
    repeat (30) @(negedge clk);
    chk("b_one_frame_per_start", b_dv_cnt - n0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c;
    logic ovr_seen;
    repeat (3) @(negedge clk);
    chk("a_rst_sclk", a_sclk, 1'b1);
    chk("a_rst_ncs", a_ncs, 1'b1);
    chk("a_rst_data", a_data, '0);
    chk("a_rst_dv", a_dv, 1'b0);
    chk("a_rst_busy", a_busy, 1'b0);
    chk("a_rst_ovr", a_ovr, 1'b0);
    chk("b_rst_sclk", b_sclk, 1'b1);
    chk("b_rst_ncs", b_ncs, 1'b1);
    chk("b_rst_data", b_data, '0);
    chk("b_rst_busy", b_busy, 1'b0);
    a_rst = 1'b0; b_rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset asserted while SHIFT is in bit 7
    a_skip  = 1'b1;
    a_start = 1'b1; @(negedge clk); a_start = 1'b0;
    t = 0;
    while (a_k < 8 && t < 200) begin @(negedge clk); t++; end
    if (a_k < 8) begin
      checks++; errors++;
      $display("FAIL a_bit7_timeout: reached bit %0d, expected 8", a_k);
    end
    a_rst = 1'b1; @(negedge clk);
    chk("a_midrst_ncs", a_ncs, 1'b1);
    chk("a_midrst_sclk", a_sclk, 1'b1);
    chk("a_midrst_busy", a_busy, 1'b0);
    a_rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("a_midrst_no_dv", a_dv_cnt, 0);
    chk("a_midrst_data", a_data, '0);
    a_exp_q.delete();
    a_skip = 1'b0;

    // directed codes, then random codes with a stray start while busy
    a_fixed = 1'b1;
    a_fix[0] = 12'hA5C; a_fix[1] = 12'h000; a_fix[2] = 12'hFFF; a_fix[3] = 12'h123;
    a_shot(1'b0);
    a_fixed = 1'b0;
    for (int i = 0; i < 4; i++) a_shot(1'b1);

    // continuous mode with ignored starts sprinkled in
    a_dv_log.delete();
    ovr_seen = 1'b0;
    c = cyc;
    a_cont = 1'b1;
    for (int i = 0; i < 950; i++) begin
      a_start = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      ovr_seen = ovr_seen | a_ovr;
    end
    a_start = 1'b0;
    chk("a_cont_ovr", ovr_seen, 1'b0);
    chk("a_cont_dv_count", a_dv_log.size(), 5);
    if (a_dv_log.size() > 0) chk("a_cont_first", a_dv_log[0] - c, A_LAT);
    for (int i = 1; i < a_dv_log.size(); i++) chk("a_cont_period", a_dv_log[i] - a_dv_log[i-1], 200);
    a_cont = 1'b0;
    t = 0;
    while (a_busy !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    chk("a_cont_idle", a_busy, 1'b0);

    // instance B: two's-complement conversion at 8 bits
    b_fixed = 1'b1;
    b_fix[0] = 8'h9C; b_fix[1] = 8'h80;
    b_shot();
    b_fix[0] = 8'h7F; b_fix[1] = 8'h01;
    b_shot();
    b_fixed = 1'b0;
    for (int i = 0; i < 3; i++) b_shot();

    // short sample period: every other tick is dropped
    b_dv_log.delete();
    c = cyc;
    b_cont = 1'b1;
    while (cyc < c + 38) @(negedge clk);
    chk("b_ovr_before_drop", b_ovr, 1'b0);
    while (cyc < c + 45) @(negedge clk);
    chk("b_ovr_after_drop", b_ovr, 1'b1);
    while (cyc < c + 390) @(negedge clk);
    chk("b_ovr_sticky", b_ovr, 1'b1);
    chk("b_cont_dv_count", b_dv_log.size(), 5);
    if (b_dv_log.size() > 0) chk("b_cont_first", b_dv_log[0] - c, B_LAT);
    for (int i = 1; i < b_dv_log.size(); i++) chk("b_cont_period", b_dv_log[i] - b_dv_log[i-1], 80);
    b_cont = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_ovr_cleared", b_ovr, 1'b0);
    repeat (60) @(negedge clk);
    chk("a_queue_drained", a_exp_q.size(), 0);
    chk("b_queue_drained", b_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
